// File: rtl/demux_1to2_stream_if.sv
// Stream bundle for the 1-to-2 demux: one input port, two output channels
// and their delivered-word counters.
interface demux_1to2_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             select_n;
  logic             i_ready;
  logic [WIDTH-1:0] y0_data;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] y1_data;
  logic             y1_valid;
  logic             y1_ready;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;

  modport master (
    output i_data, i_valid, select_n, y0_ready, y1_ready,
    input  i_ready, y0_data, y0_valid, y1_data, y1_valid, cnt0, cnt1
  );

  modport slave (
    input  i_data, i_valid, select_n, y0_ready, y1_ready,
    output i_ready, y0_data, y0_valid, y1_data, y1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux_1to2_stream.sv
// 1-to-2 stream demux: each output channel owns a 2-entry FIFO and a
// wrapping count of words delivered downstream.
module demux_1to2_stream_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             full_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [7:0]       cnt_o
);
  localparam logic [1:0] DEPTH = 2'd2;

  logic [1:0][WIDTH-1:0] mem_q;
  logic                  head_q, head_d;
  logic [1:0]            occ_q, occ_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  pop;
  logic                  wr_idx;

  assign valid_o = (occ_q != 2'd0);
  assign full_o  = (occ_q == DEPTH);
  assign pop     = valid_o & ready_i;
  // Tail slot is head plus occupancy, modulo two; never used when full.
  assign wr_idx  = head_q ^ occ_q[0];
  assign data_o  = mem_q[head_q];
  assign cnt_o   = cnt_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    case ({push_i, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: ;
    endcase
    if (pop) begin
      head_d = ~head_q;
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q  <= 2'd0;
      head_q <= 1'b0;
      cnt_q  <= 8'd0;
    end else begin
      occ_q  <= occ_d;
      head_q <= head_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is not reset; contents only matter while occupancy is nonzero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx] <= data_i;
  end
endmodule

module demux_1to2_stream #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  demux_1to2_stream_if.slave bus
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]            full, push, rdy, vld;
  logic [NUM_CH-1:0][WIDTH-1:0] dout;
  logic [NUM_CH-1:0][7:0]       cnt;

  assign rdy         = {bus.y1_ready, bus.y0_ready};
  // Ready looks only at the addressed channel's registered occupancy.
  assign bus.i_ready = ~full[bus.select_n];
  assign push[0]     = bus.i_valid & bus.i_ready & ~bus.select_n;
  assign push[1]     = bus.i_valid & bus.i_ready &  bus.select_n;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    demux_1to2_stream_ch #(.WIDTH(WIDTH)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push[k]),
      .data_i  (bus.i_data),
      .ready_i (rdy[k]),
      .full_o  (full[k]),
      .valid_o (vld[k]),
      .data_o  (dout[k]),
      .cnt_o   (cnt[k])
    );
  end

  assign bus.y0_valid = vld[0];
  assign bus.y1_valid = vld[1];
  assign bus.y0_data  = dout[0];
  assign bus.y1_data  = dout[1];
  assign bus.cnt0     = cnt[0];
  assign bus.cnt1     = cnt[1];
endmodule
